mem_port_arbiter: RTL and testbench

//  Shares one single-ported synchronous RAM between the fetch stage (instruction reads) and the

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/arb_starve_counter.sv | 31 +++
 rtl/mem_port_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory port arbiter: read-owner FSM states,
// arbitration winner encoding and the starvation counter width.
package mem_arb_pkg;

  localparam int STARVE_W = 4;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_RD_IF = 2'd1,
    ARB_RD_DM = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_IF   = 2'd1,
    OWNER_DM   = 2'd2
  } owner_e;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of consecutive fetch denials; sat tells the arbiter that
// fetch must win its next contested cycle.
module arb_starve_counter
  import mem_arb_pkg::*;
#(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam logic [STARVE_W-1:0] MAX_CNT = STARVE_W'(MAX);

  logic [STARVE_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (inc && (cnt_reg != MAX_CNT)) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign sat = (cnt_reg == MAX_CNT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported synchronous RAM between instruction fetch and the
// data stage; data wins unless fetch has been starved, read data returns one cycle later.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req_i,
  input  logic [ADDR_W-1:0]     if_addr_i,
  output logic                  if_gnt_o,
  output logic                  if_rvalid_o,
  output logic [DATA_W-1:0]     if_rdata_o,
  input  logic                  dm_req_i,
  input  logic                  dm_we_i,
  input  logic [ADDR_W-1:0]     dm_addr_i,
  input  logic [DATA_W-1:0]     dm_wdata_i,
  input  logic [DATA_W/8-1:0]   dm_wstrb_i,
  output logic                  dm_gnt_o,
  output logic                  dm_rvalid_o,
  output logic [DATA_W-1:0]     dm_rdata_o,
  output logic                  ram_en_o,
  output logic                  ram_we_o,
  output logic [ADDR_W-3:0]     ram_addr_o,
  output logic [DATA_W-1:0]     ram_wdata_o,
  output logic [DATA_W/8-1:0]   ram_wstrb_o,
  input  logic [DATA_W-1:0]     ram_rdata_i,
  output logic                  stall_fetch_o,
  output logic                  stall_mem_o
);

  arb_state_e state_reg, state_next;
  owner_e     winner;
  logic       force_if;
  logic       starve_inc;
  logic       unused_addr_lsbs;

  // Byte offsets never reach the word-addressed RAM.
  assign unused_addr_lsbs = ^{if_addr_i[1:0], dm_addr_i[1:0]};

  arb_starve_counter #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .clk   (clk),
    .reset (reset),
    .inc   (starve_inc),
    .clr   (~starve_inc),
    .sat   (force_if)
  );

  always_comb begin
    winner      = OWNER_NONE;
    if_gnt_o    = 1'b0;
    dm_gnt_o    = 1'b0;
    ram_en_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    ram_wstrb_o = '0;
    if (reset) begin
      if (dm_req_i && !(force_if && if_req_i)) begin
        winner = OWNER_DM;
      end else if (if_req_i) begin
        winner = OWNER_IF;
      end
    end
    case (winner)
      OWNER_DM: begin
        dm_gnt_o   = 1'b1;
        ram_en_o   = 1'b1;
        ram_we_o   = dm_we_i;
        ram_addr_o = dm_addr_i[ADDR_W-1:2];
        // Loads present zero write data and strobes to the RAM.
        if (dm_we_i) begin
          ram_wdata_o = dm_wdata_i;
          ram_wstrb_o = dm_wstrb_i;
        end
      end
      OWNER_IF: begin
        if_gnt_o   = 1'b1;
        ram_en_o   = 1'b1;
        ram_addr_o = if_addr_i[ADDR_W-1:2];
      end
      default: ;
    endcase
  end

  assign starve_inc    = if_req_i & ~if_gnt_o;
  assign stall_fetch_o = reset & if_req_i & ~if_gnt_o;
  assign stall_mem_o   = reset & dm_req_i & ~dm_gnt_o;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= ARB_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = ARB_IDLE;
    if_rvalid_o = 1'b0;
    dm_rvalid_o = 1'b0;
    if_rdata_o  = '0;
    dm_rdata_o  = '0;
    if (if_gnt_o) begin
      state_next = ARB_RD_IF;
    end else if (dm_gnt_o && !dm_we_i) begin
      state_next = ARB_RD_DM;
    end
    // A read in flight when reset drops is discarded rather than delivered.
    if (reset) begin
      case (state_reg)
        ARB_RD_IF: begin
          if_rvalid_o = 1'b1;
          if_rdata_o  = ram_rdata_i;
        end
        ARB_RD_DM: begin
          dm_rvalid_o = 1'b1;
          dm_rdata_o  = ram_rdata_i;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed table and sequences, then
// random traffic checked against a grant/latency reference model.
module tb_mem_port_arbiter;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic [3:0]  dm_wstrb;
  logic        dm_gnt, dm_rvalid;
  logic [31:0] dm_rdata;
  logic        ram_en, ram_we;
  logic [29:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_wstrb;
  logic [31:0] ram_rdata = '0;
  logic        stall_fetch, stall_mem;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
    .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
    .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr),
    .dm_wdata_i(dm_wdata), .dm_wstrb_i(dm_wstrb), .dm_gnt_o(dm_gnt),
    .dm_rvalid_o(dm_rvalid), .dm_rdata_o(dm_rdata),
    .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
    .ram_wdata_o(ram_wdata), .ram_wstrb_o(ram_wstrb), .ram_rdata_i(ram_rdata),
    .stall_fetch_o(stall_fetch), .stall_mem_o(stall_mem)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM, one cycle read latency.
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        for (int b = 0; b < 4; b++)
          if (ram_wstrb[b]) mem[ram_addr[7:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
      end else begin
        ram_rdata <= mem[ram_addr[7:0]];
      end
    end
  end

  function automatic logic [31:0] init_word(input int i);
    return 32'hA500_0000 | (i * 32'h0001_0101);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                        input logic [31:0] da, input logic [31:0] dd, input logic [3:0] ds);
    if_req = ir; if_addr = ia; dm_req = dr; dm_we = dw;
    dm_addr = da; dm_wdata = dd; dm_wstrb = ds;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       ir, dr, dw;
    logic [6:0] exp;  // {if_gnt, dm_gnt, stall_fetch, stall_mem, if_rvalid, dm_rvalid, ram_we}
  } vec_t;
  vec_t vecs [9];

  // Reference model state
  logic [31:0] shadow [0:255];
  int          denied;
  int          pend_owner;  // 0 none, 1 fetch, 2 data
  logic [31:0] pend_data;

  initial begin
    logic [6:0] got;
    vecs[0] = '{1'b1, 1'b1, 1'b0, 7'b0110000};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 7'b0110010};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 7'b0110010};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 7'b0110010};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 7'b1001010};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 7'b0110100};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 7'b0100011};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 7'b1000000};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 7'b0000100};

    for (int i = 0; i < 256; i++) mem[i] = init_word(i);
    mem[16] = 32'hDEADBEEF;
    mem[32] = 32'hAABBCCDD;

    // Reset held low with both requesters active
    reset = 1'b0;
    set_in(1'b1, 32'h40, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    tick;
    for (int i = 0; i < 2; i++) begin
      #2;
      chk("rst_gnt", {30'd0, if_gnt, dm_gnt}, 32'd0);
      chk("rst_ram_en", {31'd0, ram_en}, 32'd0);
      chk("rst_rvalid", {30'd0, if_rvalid, dm_rvalid}, 32'd0);
      chk("rst_stall", {30'd0, stall_fetch, stall_mem}, 32'd0);
      tick;
    end

    // Fetch alone after release, then its read response
    reset = 1'b1;
    set_in(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #2;
    chk("if_gnt_first", {31'd0, if_gnt}, 32'd1);
    chk("if_ram_addr", {2'd0, ram_addr}, 32'h10);
    chk("if_ram_en_we", {30'd0, ram_en, ram_we}, 32'd2);
    tick;
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #2;
    chk("if_rvalid", {31'd0, if_rvalid}, 32'd1);
    chk("if_rdata", if_rdata, 32'hDEADBEEF);
    tick;

    // Starvation table
    for (int i = 0; i < 9; i++) begin
      set_in(vecs[i].ir, 32'h0, vecs[i].dr, vecs[i].dw, 32'h3FC, 32'hCAFEF00D, 4'hF);
      #2;
      got = {if_gnt, dm_gnt, stall_fetch, stall_mem, if_rvalid, dm_rvalid, ram_we};
      chk($sformatf("table_row%0d", i), {25'd0, got}, {25'd0, vecs[i].exp});
      tick;
    end

    // Partial store then load of the same word
    set_in(1'b0, 32'h0, 1'b1, 1'b1, 32'h80, 32'h12345678, 4'b0011);
    #2;
    chk("st_gnt_we", {30'd0, dm_gnt, ram_we}, 32'd3);
    chk("st_addr", {2'd0, ram_addr}, 32'h20);
    chk("st_wstrb", {28'd0, ram_wstrb}, 32'h3);
    chk("st_wdata", ram_wdata, 32'h12345678);
    tick;
    set_in(1'b0, 32'h0, 1'b1, 1'b0, 32'h80, 32'hFFFFFFFF, 4'hF);
    #2;
    chk("ld_no_rvalid_after_st", {31'd0, dm_rvalid}, 32'd0);
    chk("ld_we_strb", {27'd0, ram_we, ram_wstrb}, 32'd0);
    tick;
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #2;
    chk("ld_rvalid", {31'd0, dm_rvalid}, 32'd1);
    chk("ld_merged", dm_rdata, 32'hAABB5678);
    tick;

    // Back-to-back fetches
    for (int i = 0; i < 5; i++) begin
      if (i < 3) set_in(1'b1, 32'(i * 4), 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      else       set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      #2;
      if (i >= 1 && i <= 3) begin
        chk($sformatf("b2b_rvalid%0d", i), {31'd0, if_rvalid}, 32'd1);
        chk($sformatf("b2b_rdata%0d", i), if_rdata, init_word(i - 1));
      end else if (i == 4) begin
        chk("b2b_rvalid_end", {31'd0, if_rvalid}, 32'd0);
      end
      tick;
    end

    // Reset while a load is in flight, with starvation partially built up
    set_in(1'b1, 32'h0, 1'b1, 1'b0, 32'h44, 32'h0, 4'h0);
    for (int i = 0; i < 3; i++) begin
      #2;
      chk($sformatf("rif_pre_dm_gnt%0d", i), {31'd0, dm_gnt}, 32'd1);
      tick;
    end
    reset = 1'b0;
    #2;
    chk("rif_rvalid_discard", {31'd0, dm_rvalid}, 32'd0);
    chk("rif_rdata_zero", dm_rdata, 32'd0);
    tick;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #2;
      if (i == 0) chk("rif_idle_rvalid", {31'd0, dm_rvalid}, 32'd0);
      chk($sformatf("rif_post_gnt%0d", i), {30'd0, if_gnt, dm_gnt},
          (i == 4) ? 32'd2 : 32'd1);
      tick;
    end
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick;
    tick;

    // Random traffic against the reference model
    for (int i = 0; i < 256; i++) shadow[i] = mem[i];
    denied = 0;
    pend_owner = 0;
    pend_data = '0;
    for (int n = 0; n < 300; n++) begin
      logic        ir, dr, dw, e_if, e_dm, frc;
      logic [31:0] ia, da, dd;
      logic [3:0]  ds;
      ir = ($urandom % 10) < 6;
      dr = ($urandom % 10) < 6;
      dw = ($urandom % 3) == 0;
      ia = $urandom_range(0, 1023);
      da = $urandom_range(0, 1023);
      dd = $urandom;
      ds = 4'($urandom_range(0, 15));
      set_in(ir, ia, dr, dw, da, dd, ds);
      #2;
      frc  = (denied == STARVE_MAX);
      e_dm = dr && !(frc && ir);
      e_if = ir && !e_dm;
      chk("rnd_gnt", {30'd0, if_gnt, dm_gnt}, {30'd0, e_if, e_dm});
      chk("rnd_stall", {30'd0, stall_fetch, stall_mem}, {30'd0, ir && !e_if, dr && !e_dm});
      chk("rnd_ram_en_we", {30'd0, ram_en, ram_we}, {30'd0, e_if || e_dm, e_dm && dw});
      if (e_dm) chk("rnd_ram_addr_dm", {2'd0, ram_addr}, da >> 2);
      if (e_if) chk("rnd_ram_addr_if", {2'd0, ram_addr}, ia >> 2);
      if (e_dm && dw) begin
        chk("rnd_wstrb", {28'd0, ram_wstrb}, {28'd0, ds});
        chk("rnd_wdata", ram_wdata, dd);
      end
      chk("rnd_rvalid", {30'd0, if_rvalid, dm_rvalid},
          {30'd0, pend_owner == 1, pend_owner == 2});
      chk("rnd_if_rdata", if_rdata, (pend_owner == 1) ? pend_data : 32'd0);
      chk("rnd_dm_rdata", dm_rdata, (pend_owner == 2) ? pend_data : 32'd0);
      pend_owner = 0;
      if (e_if) begin
        pend_owner = 1;
        pend_data  = shadow[ia[9:2]];
      end else if (e_dm && !dw) begin
        pend_owner = 2;
        pend_data  = shadow[da[9:2]];
      end else if (e_dm && dw) begin
        for (int b = 0; b < 4; b++)
          if (ds[b]) shadow[da[9:2]][8*b +: 8] = dd[8*b +: 8];
      end
      if (ir && !e_if) denied = (denied < STARVE_MAX) ? denied + 1 : STARVE_MAX;
      else             denied = 0;
      tick;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
